wb_regfile: RTL

Writeback-side register file for the execute stage of the dual-issue pipeline. It accepts the `{result, rd}` writeback buses produced by the two ALU lanes and commits them to the 8×16 architectural register file, with r7 holding the compare flags. It serves four combinational read ports to decode/issue and keeps a per-register busy scoreboard: issue sets a register's bit and writeback clears it. A saturating commit counter is provided for performance monitoring.

---
 rtl/wb_regfile.sv | 97 +++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Dual-lane writeback register file (8x16, r7 = flags) with busy scoreboard and commit counter.
// Optional same-cycle read bypass of writeback data: define WB_BYPASS_EN.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int RD_W   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wb0_valid,
  input  logic [DATA_W+RD_W-1:0] wb0_bus,
  input  logic                   wb1_valid,
  input  logic [DATA_W+RD_W-1:0] wb1_bus,
  input  logic                   issue_valid,
  input  logic [RD_W-1:0]        issue_rd,
  input  logic [RD_W-1:0]        raddr0,
  input  logic [RD_W-1:0]        raddr1,
  input  logic [RD_W-1:0]        raddr2,
  input  logic [RD_W-1:0]        raddr3,
  output logic [DATA_W-1:0]      rdata0,
  output logic [DATA_W-1:0]      rdata1,
  output logic [DATA_W-1:0]      rdata2,
  output logic [DATA_W-1:0]      rdata3,
  output logic [NREG-1:0]        busy,
  output logic                   wb_conflict,
  output logic [15:0]            commit_cnt
);

  logic [DATA_W-1:0] regs [NREG];
  logic [RD_W-1:0]   wb0_rd, wb1_rd;
  logic [DATA_W-1:0] wb0_data, wb1_data;
  logic              collide, wr0_en;
  logic [NREG-1:0]   busy_nxt;
  logic [1:0]        n_commit;
  logic [16:0]       cnt_sum;
  logic [RD_W-1:0]   raddr [4];
  logic [DATA_W-1:0] rdata [4];

  assign wb0_rd   = wb0_bus[RD_W-1:0];
  assign wb1_rd   = wb1_bus[RD_W-1:0];
  assign wb0_data = wb0_bus[DATA_W+RD_W-1:RD_W];
  assign wb1_data = wb1_bus[DATA_W+RD_W-1:RD_W];

  // Lane 1 is younger, so on a same-rd collision lane 0's write is dropped.
  assign collide = wb0_valid && wb1_valid && (wb0_rd == wb1_rd);
  assign wr0_en  = wb0_valid && !collide;

  assign n_commit = {1'b0, wr0_en} + {1'b0, wb1_valid};
  assign cnt_sum  = {1'b0, commit_cnt} + {15'b0, n_commit};

  always_comb begin
    busy_nxt = busy;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (issue_valid && issue_rd == RD_W'(i))
        busy_nxt[i] = 1'b1;
      else if ((wb0_valid && wb0_rd == RD_W'(i)) || (wb1_valid && wb1_rd == RD_W'(i)))
        busy_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      busy        <= '0;
      wb_conflict <= 1'b0;
      commit_cnt  <= '0;
    end else begin
      if (wr0_en)    regs[wb0_rd] <= wb0_data;
      if (wb1_valid) regs[wb1_rd] <= wb1_data;
      busy        <= busy_nxt;
      wb_conflict <= collide;
      commit_cnt  <= cnt_sum[16] ? '1 : cnt_sum[15:0];
    end
  end

  assign raddr[0] = raddr0;
  assign raddr[1] = raddr1;
  assign raddr[2] = raddr2;
  assign raddr[3] = raddr3;

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      rdata[k] = regs[raddr[k]];
`ifdef WB_BYPASS_EN
      // Lane 1 checked last so it takes priority over lane 0.
      if (wb0_valid && wb0_rd == raddr[k]) rdata[k] = wb0_data;
      if (wb1_valid && wb1_rd == raddr[k]) rdata[k] = wb1_data;
`endif
    end
  end

  assign rdata0 = rdata[0];
  assign rdata1 = rdata[1];
  assign rdata2 = rdata[2];
  assign rdata3 = rdata[3];

endmodule
